mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, ACCESS-state cycle limit before abort (used only with MEM_STAGE_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in  input  1 each  control bits from the EX/MEM register.
REQ-005 SHALL have ports alu_out_in  input  32  address or ALU result; mem_wd_in  input  32  store data; rfile_wn_in  input  5  destination register.
REQ-006 SHALL have ports dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32; dmem_wdata  output  32  data-memory request bus.
REQ-007 SHALL have ports dmem_ack  input  1; dmem_rdata  input  32  data-memory completion and read data.
REQ-008 SHALL have port stall  output  1  high = upstream EX/MEM register holds (drives its en_reg low).
REQ-009 SHALL have outputs MemtoReg_out, RegWrite_out  1 each; alu_out_out, mem_rd_out  32 each; rfile_wn_out  5  MEM/WB register contents.
REQ-010 SHALL have port mem_err  output  1  sticky access-timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE and ACCESS.
REQ-012 IDLE, MemRead_in=0 and MemWrite_in=0: stall=0; at next edge MEM/WB loads MemtoReg/RegWrite/alu_out/rfile_wn from inputs, mem_rd_out=0; latency 1 cycle.
REQ-013 IDLE, MemRead_in=1 or MemWrite_in=1: stall=1 combinationally; at next edge latch addr/wdata/we/control/wn into internal request registers, go ACCESS, load MEM/WB with a bubble (RegWrite_out=0, MemtoReg_out=0).
REQ-014 MemRead_in=1 and MemWrite_in=1 together SHALL be treated as a write (dmem_we=1).
REQ-015 ACCESS: dmem_req=1 and dmem_addr/dmem_wdata/dmem_we driven from request registers, stable until ack; stall=1 while dmem_ack=0.
REQ-016 ACCESS with dmem_ack=1: stall=0 that cycle; at the edge MEM/WB loads latched control, alu_out_out=latched address, mem_rd_out=dmem_rdata (0 for writes); state IDLE.
REQ-017 Each ACCESS cycle without ack SHALL load a bubble into MEM/WB, so RegWrite_out is high exactly one cycle per instruction.
REQ-018 Minimum memory-op latency SHALL be 2 cycles (ack in first ACCESS cycle); dmem_req SHALL be 0 in IDLE.
REQ-019 dmem_ack in IDLE SHALL be ignored.
REQ-020 Inputs SHALL be sampled only in IDLE; changes during ACCESS SHALL have no effect.

Reset
REQ-021 rst=0 SHALL asynchronously force state IDLE, timeout counter 0, request registers 0, all MEM/WB outputs 0, mem_err 0.
REQ-022 During and immediately after reset, dmem_req SHALL be 0 and stall SHALL follow REQ-012/013 from IDLE; reset during ACCESS SHALL drop dmem_req without waiting for ack.

Configuration
REQ-023 Macro MEM_STAGE_TIMEOUT_EN defined: counter increments each ACCESS cycle without ack; when it reaches TIMEOUT_CYCLES, deassert dmem_req, return to IDLE, load bubble, stall=0 that cycle, set mem_err=1 (sticky until reset); counter clears on entering ACCESS.
REQ-024 Macro undefined: no counter; ACCESS waits indefinitely for dmem_ack; mem_err tied 0.

Verification
REQ-025 ALU op alu_out_in=0x0000_0010, rfile_wn_in=5, RegWrite_in=1 -> next cycle alu_out_out=0x10, rfile_wn_out=5, RegWrite_out=1, stall never high.
REQ-026 Load addr 0x100, dmem_ack 3 cycles after dmem_req rises, dmem_rdata=0xDEADBEEF -> stall high 4 cycles, mem_rd_out=0xDEADBEEF, RegWrite_out high one cycle only.
REQ-027 Store addr 0x200, mem_wd_in=0x12345678, ack first ACCESS cycle -> dmem_we=1, dmem_wdata=0x12345678, 2-cycle latency, mem_rd_out=0.
REQ-028 rst=0 mid-ACCESS -> dmem_req, stall (from IDLE, no mem op), all outputs 0 without a clock edge; stray dmem_ack in IDLE -> no output change.
REQ-029 MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> dmem_req drops after 4 ACCESS cycles, mem_err=1, stall released; without macro dmem_req stays high after 100 cycles.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a stalling data-memory handshake feeding the MEM/WB register
// Ports: clk, rst (asynchronous, active-low); *_in are EX/MEM register contents;
//   dmem_req/dmem_we/dmem_addr/dmem_wdata form the request bus, dmem_ack/dmem_rdata the completion;
//   stall holds the EX/MEM register; *_out are MEM/WB register contents; mem_err is a sticky timeout flag.
// Define MEM_STAGE_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES cycles without dmem_ack.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] mem_wd_in,
  input  logic [4:0]  rfile_wn_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic [31:0] alu_out_out,
  output logic [31:0] mem_rd_out,
  output logic [4:0]  rfile_wn_out,
  output logic        mem_err
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t r_state, w_next;
  logic [31:0] r_addr, r_wdata;
  logic [4:0]  r_wn;
  logic        r_we, r_mtr, r_rw;
  logic        w_mem_op, w_to, w_ld_alu, w_ld_mem;
  assign w_mem_op   = MemRead_in | MemWrite_in;
  assign w_ld_alu   = (r_state == IDLE) && !w_mem_op;
  assign w_ld_mem   = (r_state == ACCESS) && dmem_ack;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // abort on the last permitted ACCESS cycle so the request drops right after it
  assign w_to = (r_state == ACCESS) && !dmem_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      mem_err <= 1'b0;
    end else begin
      r_cnt   <= (r_state == ACCESS && !dmem_ack) ? r_cnt + 1'b1 : '0;
      mem_err <= mem_err | w_to;
    end
  end
`else
  assign w_to    = 1'b0;
  assign mem_err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next   = r_state;
    dmem_req = 1'b0;
    stall    = 1'b0;
    if (r_state == IDLE) begin
      stall  = w_mem_op;
      w_next = w_mem_op ? ACCESS : IDLE;
    end else begin
      dmem_req = 1'b1;
      stall    = !(dmem_ack || w_to);
      w_next   = (dmem_ack || w_to) ? IDLE : ACCESS;
    end
  end
  // a simultaneous read and write request is issued as a write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wn    <= '0;
      r_we    <= 1'b0;
      r_mtr   <= 1'b0;
      r_rw    <= 1'b0;
    end else if (r_state == IDLE && w_mem_op) begin
      r_addr  <= alu_out_in;
      r_wdata <= mem_wd_in;
      r_wn    <= rfile_wn_in;
      r_we    <= MemWrite_in;
      r_mtr   <= MemtoReg_in;
      r_rw    <= RegWrite_in;
    end
  end
  // anything other than a pass-through or a completed access loads a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemtoReg_out <= 1'b0;
      RegWrite_out <= 1'b0;
      alu_out_out  <= '0;
      mem_rd_out   <= '0;
      rfile_wn_out <= '0;
    end else begin
      MemtoReg_out <= (w_ld_alu & MemtoReg_in) | (w_ld_mem & r_mtr);
      RegWrite_out <= (w_ld_alu & RegWrite_in) | (w_ld_mem & r_rw);
      alu_out_out  <= w_ld_alu ? alu_out_in : w_ld_mem ? r_addr : '0;
      rfile_wn_out <= w_ld_alu ? rfile_wn_in : w_ld_mem ? r_wn : '0;
      mem_rd_out   <= (w_ld_mem && !r_we) ? dmem_rdata : '0;
    end
  end
endmodule
